// File: rtl/aes_cbc_pkg.sv
// Shared definitions for the CBC chaining front end: FSM encoding, direction
// constants and the chaining XOR helper.
package aes_cbc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KINIT = 3'd1,
    KWAIT = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4
  } state_e;

  localparam logic ENC = 1'b1;
  localparam logic DEC = 1'b0;

  localparam int CNT_W_DEF = 32;

  function automatic logic [127:0] cbc_xor(input logic sel,
                                           input logic [127:0] a,
                                           input logic [127:0] b);
    return sel ? (a ^ b) : a;
  endfunction

endpackage

// File: rtl/aes_cbc_outbuf.sv
// Single-entry valid/ready result register between the chaining FSM and the host.
module aes_cbc_outbuf (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [127:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [127:0] data_o
);

  logic         valid_q;
  logic [127:0] data_q;

  // load_i never coincides with a held entry: the FSM stalls input while valid_o=1
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/aes_cbc_ctrl.sv
// CBC chaining controller driving the AES core's init/next/encdec/block inputs.
// state | meaning
// IDLE  | accept key_init, iv_load or an input block
// KINIT | core_init pulse
// KWAIT | wait for core key expansion (first cycle ignored)
// START | core_next pulse
// WAIT  | wait for core result (first cycle ignored)
module aes_cbc_ctrl
  import aes_cbc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_init,
  input  logic [255:0]     key,
  input  logic [1:0]       keylen,
  output logic             key_valid,
  input  logic             iv_load,
  input  logic [127:0]     iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_encdec,
  input  logic [127:0]     in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic [CNT_W-1:0] blocks_done,
  output logic             core_init,
  output logic             core_next,
  output logic             core_encdec,
  output logic [255:0]     core_key,
  output logic [1:0]       core_keylen,
  output logic [127:0]     core_block,
  input  logic             core_ready,
  input  logic             core_result_valid,
  input  logic [127:0]     core_result
);

  state_e           state_q;
  logic             key_valid_q;
  logic             core_init_q;
  logic             core_next_q;
  logic             core_encdec_q;
  logic             armed_q;
  logic [255:0]     core_key_q;
  logic [1:0]       core_keylen_q;
  logic [127:0]     core_block_q;
  logic [127:0]     chain_q;
  logic [127:0]     saved_in_q;
  logic [CNT_W-1:0] blocks_done_q;

  logic             accept;
  logic             block_done;
  logic             out_valid_w;
  logic [127:0]     result_d;
  logic [127:0]     chain_d;

  assign in_ready   = (state_q == IDLE) & key_valid_q & ~out_valid_w & ~key_init & ~iv_load;
  assign accept     = in_valid & in_ready;
  assign block_done = (state_q == WAIT) & armed_q & core_ready & core_result_valid;

  // Decipher XORs the chain after the core and chains on the original ciphertext
  assign result_d = cbc_xor(core_encdec_q == DEC, core_result, chain_q);
  assign chain_d  = (core_encdec_q == ENC) ? core_result : saved_in_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      key_valid_q   <= 1'b0;
      core_init_q   <= 1'b0;
      core_next_q   <= 1'b0;
      core_encdec_q <= 1'b0;
      armed_q       <= 1'b0;
      core_key_q    <= '0;
      core_keylen_q <= '0;
      core_block_q  <= '0;
      chain_q       <= '0;
      saved_in_q    <= '0;
      blocks_done_q <= '0;
    end else begin
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_init) begin
            core_key_q    <= key;
            core_keylen_q <= keylen;
            key_valid_q   <= 1'b0;
            core_init_q   <= 1'b1;
            state_q       <= KINIT;
          end else if (iv_load) begin
            chain_q <= iv;
          end else if (accept) begin
            core_encdec_q <= in_encdec;
            saved_in_q    <= in_block;
            core_block_q  <= cbc_xor(in_encdec == ENC, in_block, chain_q);
            core_next_q   <= 1'b1;
            state_q       <= START;
          end
        end
        KINIT: begin
          armed_q <= 1'b0;
          state_q <= KWAIT;
        end
        KWAIT: begin
          armed_q <= 1'b1;
          if (armed_q && core_ready) begin
            key_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        START: begin
          armed_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          armed_q <= 1'b1;
          if (block_done) begin
            chain_q       <= chain_d;
            blocks_done_q <= blocks_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  aes_cbc_outbuf u_outbuf (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (block_done),
    .data_i  (result_d),
    .ready_i (out_ready),
    .valid_o (out_valid_w),
    .data_o  (out_block)
  );

  assign out_valid   = out_valid_w;
  assign key_valid   = key_valid_q;
  assign core_init   = core_init_q;
  assign core_next   = core_next_q;
  assign core_encdec = core_encdec_q;
  assign core_key    = core_key_q;
  assign core_keylen = core_keylen_q;
  assign core_block  = core_block_q;
  assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Bench for aes_cbc_ctrl: behavioural AES-128 core model plus a CBC reference
// model computed from the chaining definition.
module tb_aes_cbc_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             key_init = 1'b0;
  logic [255:0]     key = '0;
  logic [1:0]       keylen = '0;
  logic             key_valid;
  logic             iv_load = 1'b0;
  logic [127:0]     iv = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_encdec = 1'b0;
  logic [127:0]     in_block = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [127:0]     out_block;
  logic [CNT_W-1:0] blocks_done;
  logic             core_init;
  logic             core_next;
  logic             core_encdec;
  logic [255:0]     core_key;
  logic [1:0]       core_keylen;
  logic [127:0]     core_block;
  logic             core_ready = 1'b1;
  logic             core_result_valid = 1'b0;
  logic [127:0]     core_result = '0;

  always #5 clk = ~clk;

  aes_cbc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .key_init          (key_init),
    .key               (key),
    .keylen            (keylen),
    .key_valid         (key_valid),
    .iv_load           (iv_load),
    .iv                (iv),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_encdec         (in_encdec),
    .in_block          (in_block),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_block         (out_block),
    .blocks_done       (blocks_done),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_encdec       (core_encdec),
    .core_key          (core_key),
    .core_keylen       (core_keylen),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_result_valid (core_result_valid),
    .core_result       (core_result)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int next_pulses = 0;
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] m_key = '0;
  logic [127:0] m_chain = '0;
  int           m_done = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  // Plain FIPS-197 AES-128 (textbook round structure)
  function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] blk,
                                          input logic enc);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   m [4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   acc;
    logic [127:0] res;
    int           r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
    if (enc) m = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int n = 0; n <= 10; n++) begin
      r = enc ? n : 10 - n;
      if (n > 0) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++)
            if (enc) t[row+4*c] = sbox[s[row+4*((c+row)%4)]];
            else     t[row+4*((c+row)%4)] = isbox[s[row+4*c]];
        s = t;
      end
      if (!enc) for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      if (n > 0 && n < 10) begin
        for (int c = 0; c < 4; c++)
          for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(s[4*c+j], m[(j-i+4)%4]);
            t[4*c+i] = acc;
          end
        s = t;
      end
      if (enc) for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Core model: ready drops the cycle after init/next, result after a random latency
  initial begin : core_model
    logic         s_rst, s_init, s_next, s_enc, pend;
    logic [127:0] s_blk, s_key;
    int           cnt;
    cnt = 0; pend = 1'b0;
    forever begin
      @(negedge clk);
      s_rst = reset_n; s_init = core_init; s_next = core_next;
      s_enc = core_encdec; s_blk = core_block; s_key = core_key[255:128];
      if (core_next) next_pulses++;
      @(posedge clk); #1;
      if (!s_rst) begin
        core_ready = 1'b1; core_result_valid = 1'b0; cnt = 0; pend = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_ready = 1'b1;
          core_result_valid = pend;
        end
      end else if (s_init) begin
        core_ready = 1'b0; core_result_valid = 1'b0; pend = 1'b0;
        cnt = $urandom_range(3, 8);
      end else if (s_next) begin
        core_ready = 1'b0; core_result_valid = 1'b0; pend = 1'b1;
        core_result = aes128(s_key, s_blk, s_enc);
        cnt = $urandom_range(3, 8);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [127:0] k, input logic offer);
    logic early;
    logic ok;
    key = {k, 128'h0}; keylen = 2'b00; key_init = 1'b1;
    if (offer) begin
      in_valid = 1'b1; in_block = rnd128(); in_encdec = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL key_init_vs_in: in_ready %b want 0", in_ready); end
    end
    step();
    key_init = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (core_init !== 1'b1) begin n_bad++; $display("FAIL core_init: got %b want 1", core_init); end
    n_cmp++;
    if (core_key !== {k, 128'h0}) begin n_bad++; $display("FAIL core_key: got %h want %h", core_key, {k, 128'h0}); end
    early = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (key_valid === 1'b1) begin ok = 1'b1; break; end
      if (in_ready !== 1'b0) early = 1'b1;
      step();
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL key_valid_timeout: key_valid %b want 1", key_valid); end
    n_cmp++;
    if (early) begin n_bad++; $display("FAIL in_ready_before_key: saw 1 want 0"); end
    m_key = k;
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv = v; iv_load = 1'b1;
    step();
    iv_load = 1'b0;
    m_chain = v;
  endtask

  task automatic run_block(input logic [127:0] blk, input logic enc, input int hold,
                           output logic [127:0] res);
    logic [127:0] exp_core;
    logic [127:0] exp_out;
    logic         ok;
    logic         held;
    exp_core = enc ? (blk ^ m_chain) : blk;
    exp_out  = enc ? aes128(m_key, blk ^ m_chain, 1'b1) : (aes128(m_key, blk, 1'b0) ^ m_chain);
    res = '0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL in_ready_timeout: in_ready %b want 1", in_ready); return; end
    in_block = blk; in_encdec = enc; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_block = rnd128(); in_encdec = ~enc;
    n_cmp++;
    if (core_next !== 1'b1) begin n_bad++; $display("FAIL core_next_latency: got %b want 1", core_next); end
    n_cmp++;
    if (core_block !== exp_core) begin n_bad++; $display("FAIL core_block: got %h want %h", core_block, exp_core); end
    n_cmp++;
    if (core_encdec !== enc) begin n_bad++; $display("FAIL core_encdec: got %b want %b", core_encdec, enc); end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL out_valid_timeout: out_valid %b want 1", out_valid); return; end
    res = out_block;
    m_done++;
    m_chain = enc ? exp_out : blk;
    n_cmp++;
    if (out_block !== exp_out) begin n_bad++; $display("FAIL out_block: got %h want %h", out_block, exp_out); end
    held = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (out_valid !== 1'b1 || out_block !== res || in_ready !== 1'b0) held = 1'b0;
    end
    if (hold > 0) begin
      n_cmp++;
      if (!held) begin n_bad++; $display("FAIL backpressure_hold: out_valid %b in_ready %b want 1/0", out_valid, in_ready); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL out_valid_clear: got %b want 0", out_valid); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_after_xfer: got %b want 1", in_ready); end
    n_cmp++;
    if (blocks_done !== CNT_W'(m_done)) begin n_bad++; $display("FAIL blocks_done: got %0d want %0d", blocks_done, m_done); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(2);
    n_cmp++;
    if ({key_valid, out_valid, in_ready, core_init, core_next, core_encdec} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000",
                        {key_valid, out_valid, in_ready, core_init, core_next, core_encdec});
    end
    n_cmp++;
    if (core_block !== '0) begin n_bad++; $display("FAIL reset_core_block: got %h want 0", core_block); end
    n_cmp++;
    if ({core_key, core_keylen} !== '0) begin n_bad++; $display("FAIL reset_core_key: got %h want 0", {core_key, core_keylen}); end
    n_cmp++;
    if (blocks_done !== '0) begin n_bad++; $display("FAIL reset_blocks_done: got %0d want 0", blocks_done); end
    reset_n = 1'b1;
    m_chain = '0; m_done = 0;
    step();
  endtask

  task automatic test_fips197();
    logic [127:0] r;
    load_key(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    load_iv('0);
    run_block(128'h00112233445566778899aabbccddeeff, 1'b1, 0, r);
    n_cmp++;
    if (r !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin n_bad++; $display("FAIL fips197: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", r); end
    n_cmp++;
    if (blocks_done !== 32'd1) begin n_bad++; $display("FAIL fips197_count: got %0d want 1", blocks_done); end
  endtask

  task automatic test_cbc_vectors();
    logic [127:0] r;
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    load_iv(128'h000102030405060708090a0b0c0d0e0f);
    run_block(128'h6bc1bee22e409f96e93d7e117393172a, 1'b1, 0, r);
    n_cmp++;
    if (r !== 128'h7649abac8119b246cee98e9b12e9197d) begin n_bad++; $display("FAIL cbc_enc_c1: got %h want 7649abac8119b246cee98e9b12e9197d", r); end
    run_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1, 0, r);
    n_cmp++;
    if (r !== 128'h5086cb9b507219ee95db113a917678b2) begin n_bad++; $display("FAIL cbc_enc_c2: got %h want 5086cb9b507219ee95db113a917678b2", r); end
  endtask

  task automatic test_decipher();
    logic [127:0] r;
    load_iv(128'h000102030405060708090a0b0c0d0e0f);
    run_block(128'h7649abac8119b246cee98e9b12e9197d, 1'b0, 0, r);
    n_cmp++;
    if (r !== 128'h6bc1bee22e409f96e93d7e117393172a) begin n_bad++; $display("FAIL cbc_dec_p1: got %h want 6bc1bee22e409f96e93d7e117393172a", r); end
    run_block(128'h5086cb9b507219ee95db113a917678b2, 1'b0, 0, r);
    n_cmp++;
    if (r !== 128'hae2d8a571e03ac9c9eb76fac45af8e51) begin n_bad++; $display("FAIL cbc_dec_p2: got %h want ae2d8a571e03ac9c9eb76fac45af8e51", r); end
  endtask

  task automatic test_backpressure();
    logic [127:0] r;
    run_block(rnd128(), 1'b1, 20, r);
  endtask

  task automatic test_simultaneous();
    logic [127:0] r;
    int           p0;
    p0 = next_pulses;
    load_key(rnd128(), 1'b1);
    step(3);
    n_cmp++;
    if (next_pulses != p0) begin n_bad++; $display("FAIL key_init_next_pulse: pulses %0d want %0d", next_pulses, p0); end
    iv = rnd128(); iv_load = 1'b1; in_valid = 1'b1; in_block = rnd128(); in_encdec = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL iv_load_in_ready: got %b want 0", in_ready); end
    step();
    iv_load = 1'b0; in_valid = 1'b0;
    m_chain = iv;
    step(3);
    n_cmp++;
    if (next_pulses != p0) begin n_bad++; $display("FAIL iv_load_next_pulse: pulses %0d want %0d", next_pulses, p0); end
    run_block(rnd128(), 1'b1, 0, r);
  endtask

  task automatic test_random();
    logic [127:0] r;
    load_key(rnd128(), 1'b0);
    load_iv(rnd128());
    for (int i = 0; i < 12; i++)
      run_block(rnd128(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), r);
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [127:0] r;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL reset_mid_ready: in_ready %b want 1", in_ready); end
    in_block = rnd128(); in_encdec = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_cmp++;
    if ({key_valid, out_valid, in_ready, core_init, core_next, core_encdec} !== 6'b0) begin
      n_bad++; $display("FAIL reset_mid_ctrl: got %b want 000000",
                        {key_valid, out_valid, in_ready, core_init, core_next, core_encdec});
    end
    n_cmp++;
    if (blocks_done !== '0) begin n_bad++; $display("FAIL reset_mid_count: got %0d want 0", blocks_done); end
    n_cmp++;
    if ({core_block, core_key} !== '0) begin n_bad++; $display("FAIL reset_mid_core_data: got nonzero want 0"); end
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid !== 1'b0 || key_valid !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL reset_mid_aborted: out_valid %b key_valid %b want 0/0", out_valid, key_valid); end
    m_chain = '0; m_done = 0;
    load_key(rnd128(), 1'b0);
    run_block(rnd128(), 1'b1, 0, r);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips197();
    test_cbc_vectors();
    test_decipher();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
